// File: rtl/time_set_ctrl.sv
// Mode/edit controller for the HH:MM display: captures the running time into an
// edit buffer, edits one digit at a time, and pulses load with the new time.
module time_set_ctrl #(
   parameter int HALF_SEC = 25_000_000,
   parameter int TIMEOUT  = 500_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_mode,
   input  logic       btn_sel,
   input  logic       btn_inc,
   input  logic [3:0] H_0_T,
   input  logic [3:0] H_1_T,
   input  logic [3:0] H_2_T,
   input  logic [3:0] H_3_T,
   output logic [3:0] H_0_W,
   output logic [3:0] H_1_W,
   output logic [3:0] H_2_W,
   output logic [3:0] H_3_W,
   output logic       dsp_Hex,
   output logic [1:0] Hex_bit,
   output logic       led_setting,
   output logic       led_point,
   output logic       load,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

   state_t          state_q, state_d;
   logic [2:0]      btn_prev;
   logic [3:0][3:0] dig_q, dig_d;
   logic [1:0]      sel_q, sel_d;
   logic            dsp_q, dsp_d, set_q, set_d, pt_q, pt_d, load_q, load_d, busy_q, busy_d;
   logic [31:0]     blink_q, blink_d, to_q, to_d;
   logic            edge_mode, edge_sel, edge_inc;
   logic            p_mode, p_sel, p_inc;
   logic [3:0]      lim, cur, inc_val;

   assign edge_mode = btn_mode & ~btn_prev[2];
   assign edge_sel  = btn_sel  & ~btn_prev[1];
   assign edge_inc  = btn_inc  & ~btn_prev[0];
   assign p_mode    = edge_mode;
   assign p_sel     = edge_sel & ~edge_mode;
   assign p_inc     = edge_inc & ~edge_sel & ~edge_mode;

   // Per-digit wrap limit; hour units shrinks to 0..3 in the twenties.
   always_comb begin
      lim = 4'd9;
      case (sel_q)
         2'd3: lim = 4'd2;
         2'd2: lim = (dig_q[3] == 4'd2) ? 4'd3 : 4'd9;
         2'd1: lim = 4'd5;
         default: lim = 4'd9;
      endcase
   end

   assign cur     = dig_q[sel_q];
   assign inc_val = (cur >= lim) ? 4'd0 : cur + 4'd1;

   always_comb begin
      state_d = state_q;
      dig_d   = dig_q;
      sel_d   = sel_q;
      dsp_d   = dsp_q;
      set_d   = set_q;
      pt_d    = pt_q;
      load_d  = 1'b0;
      busy_d  = busy_q;
      blink_d = blink_q;
      to_d    = to_q;
      case (state_q)
         IDLE: begin
            if (p_mode) begin
               state_d = EDIT;
               dig_d   = {H_3_T, H_2_T, H_1_T, H_0_T};
               sel_d   = 2'd3;
               to_d    = '0;
               dsp_d   = 1'b1;
               set_d   = 1'b1;
               pt_d    = 1'b1;
               busy_d  = 1'b1;
            end else if (blink_q == 32'(HALF_SEC - 1)) begin
               pt_d    = ~pt_q;
               blink_d = '0;
            end else begin
               blink_d = blink_q + 32'd1;
            end
         end
         EDIT: begin
            if (p_mode) begin
               state_d = COMMIT;
               load_d  = 1'b1;
            end else if (p_sel) begin
               sel_d = sel_q - 2'd1;
               to_d  = '0;
            end else if (p_inc) begin
               dig_d[sel_q] = inc_val;
               if (sel_q == 2'd3 && inc_val == 4'd2 && dig_q[2] > 4'd3)
                  dig_d[2] = 4'd3;
               to_d = '0;
            end else if (to_q == 32'(TIMEOUT - 1)) begin
               state_d = IDLE;
               dsp_d   = 1'b0;
               set_d   = 1'b0;
               busy_d  = 1'b0;
               blink_d = '0;
            end else begin
               to_d = to_q + 32'd1;
            end
         end
         default: begin
            // COMMIT lasts one cycle; presses seen here are dropped.
            state_d = IDLE;
            dsp_d   = 1'b0;
            set_d   = 1'b0;
            busy_d  = 1'b0;
            blink_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      btn_prev <= {btn_mode, btn_sel, btn_inc};
      if (!rst_n) begin
         state_q <= IDLE;
         dig_q   <= '0;
         sel_q   <= 2'd3;
         dsp_q   <= 1'b0;
         set_q   <= 1'b0;
         pt_q    <= 1'b0;
         load_q  <= 1'b0;
         busy_q  <= 1'b0;
         blink_q <= '0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         dig_q   <= dig_d;
         sel_q   <= sel_d;
         dsp_q   <= dsp_d;
         set_q   <= set_d;
         pt_q    <= pt_d;
         load_q  <= load_d;
         busy_q  <= busy_d;
         blink_q <= blink_d;
         to_q    <= to_d;
      end
   end

   assign H_3_W       = dig_q[3];
   assign H_2_W       = dig_q[2];
   assign H_1_W       = dig_q[1];
   assign H_0_W       = dig_q[0];
   assign Hex_bit     = sel_q;
   assign dsp_Hex     = dsp_q;
   assign led_setting = set_q;
   assign led_point   = pt_q;
   assign load        = load_q;
   assign busy        = busy_q;

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Mode/edit controller for the 4-digit HH:MM seven-segment display block.
- Watches three debounced push-buttons (mode, select, increment) and sequences display modes.
- Captures the running time into an edit buffer and lets the user change one digit at a time; the display block blinks the selected digit.
- Issues a one-cycle load pulse with the edited HH:MM so the timekeeping counter can reload.

Parameters:
HALF_SEC, 25_000_000, clk cycles per half-period of the colon LED blink (50 MHz clock)
TIMEOUT, 500_000_000, idle clk cycles in EDIT before the edit is abandoned

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
btn_mode  in  1  debounced level, active high
btn_sel  in  1  debounced level, active high
btn_inc  in  1  debounced level, active high
H_0_T..H_3_T  in  4 each  running time digits (H_0 = minute units, H_3 = hour tens)
H_0_W..H_3_W  out  4 each  edit-buffer digits to display block
dsp_Hex  out  1  0 = show time digits, 1 = show edit digits
Hex_bit  out  2  index of selected digit (3 = hour tens ... 0 = minute units)
led_setting  out  1  1 while editing (enables blink in display)
led_point  out  1  colon LED
load  out  1  one-cycle pulse; H_x_W valid as new time
busy  out  1  high in EDIT or COMMIT

Behaviour:
- Reset (rst_n = 0 at a clk edge) forces the following, all synchronously:
  - state = IDLE; H_x_W = 0; Hex_bit = 3; dsp_Hex = 0; led_setting = 0; led_point = 0; load = 0; busy = 0; all counters = 0.
  - Button history registers load the current button levels, so a button held through reset produces no edge.
- Reset mid-EDIT abandons the edit; no load pulse is issued.
- Edge detect: press = btn & ~btn_prev, evaluated each cycle.
  - The action is visible on the outputs 1 cycle after the first cycle the level is sampled high.
  - A held button acts only once.
- Press priority in the same cycle: mode > sel > inc. Lower-priority presses in that cycle are discarded.
- All outputs are registered.
- IDLE:
  - dsp_Hex = 0, led_setting = 0, busy = 0.
  - led_point toggles every HALF_SEC cycles (the counter counts 0..HALF_SEC-1, then toggles and clears).
  - mode press -> EDIT: H_x_W <= H_x_T (captured in the same cycle), Hex_bit <= 3, timeout counter cleared.
  - sel and inc presses are ignored.
- EDIT:
  - dsp_Hex = 1, led_setting = 1, led_point = 1 (steady), busy = 1.
  - sel press: Hex_bit <= Hex_bit - 1, wrapping 0 -> 3.
  - inc press: increment the selected digit, with wrap limits:
    - digit 3 (hour tens): 0..2.
    - digit 2 (hour units): 0..9, or 0..3 when H_3_W = 2.
    - digit 1 (minute tens): 0..5.
    - digit 0 (minute units): 0..9.
    - Incrementing past the limit wraps to 0.
  - Clamp: if H_3_W becomes 2 while H_2_W > 3, H_2_W <= 3 in the same cycle.
  - Any press clears the timeout counter.
  - Timeout counter reaching TIMEOUT-1 -> IDLE with no load; H_x_W is kept.
  - mode press -> COMMIT.
- COMMIT (1 cycle):
  - load = 1, H_x_W stable, busy = 1.
  - Button presses in this cycle are discarded.
  - Next state IDLE. load is high for exactly 1 cycle.
- Counter widths: 32 bits each. The blink counter runs only in IDLE and is cleared on entry to IDLE.

Test Plan:
1. Reset, then mode press with time 23:59 → next cycle: dsp_Hex = 1, led_setting = 1, H_3..0_W = 2,3,5,9, Hex_bit = 3, busy = 1.
2. In EDIT with buffer 1,5,4,7, Hex_bit = 3: inc → 2,3,4,7 (clamp); inc → 0,3,4,7; sel ×4 → Hex_bit sequence 2,1,0,3.
3. Hex_bit = 1, H_1_W = 5: inc → H_1_W = 0. Hex_bit = 0, H_0_W = 9: inc → 0. H_3_W = 1, Hex_bit = 2, H_2_W = 9: inc → 0.
4. Edited buffer 1,2,3,4, mode press → load = 1 for exactly 1 cycle with H_x_W = 1,2,3,4, then IDLE (dsp_Hex = 0); btn_mode held 20 cycles gives only one transition.
5. TIMEOUT = 16, HALF_SEC = 4: enter EDIT, no presses → IDLE after 16 cycles with load never asserted; in IDLE, led_point toggles every 4 cycles.
6. btn_mode and btn_inc rise in the same cycle in EDIT → COMMIT, digit unchanged. btn_inc held high across the rst_n deassert → no increment; rst_n low mid-EDIT → IDLE, load = 0.
